// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus bundle between the LSU/IF front ends, mem_ctrl and the RAM/IO bus.
interface mem_ctrl_if;
  logic        en_signal_from_lsu;
  logic [31:0] addr_from_lsu;
  logic [31:0] data_from_lsu;
  logic        rw_flag_from_lsu;
  logic [2:0]  size_from_lsu;
  logic        ok_flag_to_lsu;
  logic [31:0] data_to_lsu;
  logic        en_signal_from_if;
  logic [31:0] addr_from_if;
  logic        ok_flag_to_if;
  logic [31:0] inst_to_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  en_signal_from_lsu, addr_from_lsu, data_from_lsu, rw_flag_from_lsu, size_from_lsu,
    input  en_signal_from_if, addr_from_if, mem_din,
    output ok_flag_to_lsu, data_to_lsu, ok_flag_to_if, inst_to_if, mem_dout, mem_a, mem_wr
  );

  modport master (
    output en_signal_from_lsu, addr_from_lsu, data_from_lsu, rw_flag_from_lsu, size_from_lsu,
    output en_signal_from_if, addr_from_if, mem_din,
    input  ok_flag_to_lsu, data_to_lsu, ok_flag_to_if, inst_to_if, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: LSU-first arbitration, 1/2/4-byte serialisation onto an 8-bit bus.
// Optional IO write stall on a full UART buffer enabled by defining MEM_CTRL_IO_STALL_EN.
module mem_ctrl #(
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       io_buffer_full,
  input  logic       rollback_flag_from_rob,
  mem_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LS_READ  = 3'd1;
  localparam logic [2:0] S_LS_WRITE = 3'd2;
  localparam logic [2:0] S_IF_READ  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_if_q, is_if_d;
  logic        is_rd_q, is_rd_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] lsu_data_q, lsu_data_d;
  logic [31:0] inst_q, inst_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_rw_q, pend_rw_d;
  logic [2:0]  pend_size_q, pend_size_d;

  logic        rollback;
  logic        pend_go;
  logic        io_stall;
  logic        rd_state;
  logic [1:0]  bidx;

  assign rollback = rollback_flag_from_rob;
  assign rd_state = (state_q == S_LS_READ) || (state_q == S_IF_READ);
  assign bidx     = cnt_q[1:0] - 2'd1;
  // A latched read that is being flushed this cycle must not be started.
  assign pend_go  = pend_vld_q && !(rollback && !pend_rw_q);

`ifdef MEM_CTRL_IO_STALL_EN
  assign io_stall = (state_q == S_LS_WRITE) && (addr_q[17:16] == IO_BASE_HI) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full | (&IO_BASE_HI);
  assign io_stall  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_if_d     = is_if_q;
    is_rd_d     = is_rd_q;
    buf_d       = buf_q;
    lsu_data_d  = lsu_data_q;
    inst_d      = inst_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_rw_d   = pend_rw_q;
    pend_size_d = pend_size_q;

    if (state_q != S_IDLE && bus.en_signal_from_lsu &&
        !(rollback && !bus.rw_flag_from_lsu)) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = bus.addr_from_lsu;
      pend_data_d = bus.data_from_lsu;
      pend_rw_d   = bus.rw_flag_from_lsu;
      pend_size_d = bus.size_from_lsu;
    end else if (rollback && pend_vld_q && !pend_rw_q) begin
      pend_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = 3'd0;
        buf_d = 32'd0;
        if (bus.en_signal_from_lsu) begin
          addr_d  = bus.addr_from_lsu;
          wdata_d = bus.data_from_lsu;
          n_d     = bus.size_from_lsu;
          is_if_d = 1'b0;
          is_rd_d = !bus.rw_flag_from_lsu;
          state_d = bus.rw_flag_from_lsu ? S_LS_WRITE : S_LS_READ;
        end else if (pend_go) begin
          addr_d     = pend_addr_q;
          wdata_d    = pend_data_q;
          n_d        = pend_size_q;
          is_if_d    = 1'b0;
          is_rd_d    = !pend_rw_q;
          state_d    = pend_rw_q ? S_LS_WRITE : S_LS_READ;
          pend_vld_d = 1'b0;
        end else if (bus.en_signal_from_if) begin
          addr_d  = bus.addr_from_if;
          n_d     = 3'd4;
          is_if_d = 1'b1;
          is_rd_d = 1'b1;
          state_d = S_IF_READ;
        end
      end
      S_LS_READ, S_IF_READ: begin
        if (rollback) begin
          state_d = S_IDLE;
        end else begin
          // mem_din carries the byte addressed one cycle earlier
          if (cnt_q != 3'd0) buf_d[{bidx, 3'b000} +: 8] = bus.mem_din;
          if (cnt_q == n_q) begin
            state_d = S_DONE;
            if (is_if_q) inst_d = buf_d;
            else         lsu_data_d = buf_d;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_LS_WRITE: begin
        if (!io_stall) begin
          if (cnt_q == n_q - 3'd1) state_d = S_DONE;
          else                     cnt_d   = cnt_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      is_if_q     <= 1'b0;
      is_rd_q     <= 1'b0;
      buf_q       <= 32'd0;
      lsu_data_q  <= 32'd0;
      inst_q      <= 32'd0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= 32'd0;
      pend_data_q <= 32'd0;
      pend_rw_q   <= 1'b0;
      pend_size_q <= 3'd0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_if_q     <= is_if_d;
      is_rd_q     <= is_rd_d;
      buf_q       <= buf_d;
      lsu_data_q  <= lsu_data_d;
      inst_q      <= inst_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_rw_q   <= pend_rw_d;
      pend_size_q <= pend_size_d;
    end
  end

  // Bus drive is purely a function of the current state; IDLE/DONE leave the bus quiet.
  assign bus.mem_a    = ((rd_state && cnt_q < n_q) || state_q == S_LS_WRITE) ?
                        addr_q + {29'd0, cnt_q} : 32'd0;
  assign bus.mem_wr   = (state_q == S_LS_WRITE) && rdy_in && !io_stall;
  assign bus.mem_dout = (state_q == S_LS_WRITE) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

  assign bus.ok_flag_to_lsu = (state_q == S_DONE) && !is_if_q && !(is_rd_q && rollback);
  assign bus.ok_flag_to_if  = (state_q == S_DONE) && is_if_q && !rollback;
  assign bus.data_to_lsu    = lsu_data_q;
  assign bus.inst_to_if     = inst_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: reads, writes, arbitration, pending latch, rollback, freeze, reset.
module tb_mem_ctrl;
  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic io_buffer_full;
  logic rollback_flag_from_rob;
  int   checks;
  int   failures;

  mem_ctrl_if bus ();

  mem_ctrl u_dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .io_buffer_full         (io_buffer_full),
    .rollback_flag_from_rob (rollback_flag_from_rob),
    .bus                    (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: ram_byte = 8'h11;
      32'h0000_0101: ram_byte = 8'h22;
      32'h0000_0102: ram_byte = 8'h33;
      32'h0000_0103: ram_byte = 8'h44;
      32'h0000_0000: ram_byte = 8'h13;
      32'h0000_0001: ram_byte = 8'h57;
      32'h0000_0002: ram_byte = 8'h9B;
      32'h0000_0003: ram_byte = 8'hDF;
      32'h0000_0300: ram_byte = 8'h5A;
      default:       ram_byte = a[7:0] ^ 8'hC3;
    endcase
  endfunction

  // One-cycle read latency RAM
  always @(posedge clk_in) bus.mem_din <= ram_byte(bus.mem_a);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic lsu_pulse(input logic [31:0] a, input logic [31:0] d, input logic rw,
                           input logic [2:0] sz);
    bus.en_signal_from_lsu = 1'b1;
    bus.addr_from_lsu      = a;
    bus.data_from_lsu      = d;
    bus.rw_flag_from_lsu   = rw;
    bus.size_from_lsu      = sz;
  endtask

  initial begin
    logic [31:0] wv;
    checks = 0;
    failures = 0;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    io_buffer_full = 1'b0;
    rollback_flag_from_rob = 1'b0;
    bus.en_signal_from_lsu = 1'b0;
    bus.addr_from_lsu = 32'd0;
    bus.data_from_lsu = 32'd0;
    bus.rw_flag_from_lsu = 1'b0;
    bus.size_from_lsu = 3'd0;
    bus.en_signal_from_if = 1'b0;
    bus.addr_from_if = 32'd0;

    repeat (2) @(negedge clk_in);
    chk1("rst_ok_lsu", bus.ok_flag_to_lsu, 1'b0);
    chk1("rst_ok_if", bus.ok_flag_to_if, 1'b0);
    chk1("rst_mem_wr", bus.mem_wr, 1'b0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_data_lsu", bus.data_to_lsu, 32'd0);
    chk("rst_inst", bus.inst_to_if, 32'd0);
    chk("rst_dout", {24'd0, bus.mem_dout}, 32'd0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // LSU read, 4 bytes at 0x100
    lsu_pulse(32'h100, 32'd0, 1'b0, 3'd4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      chk1("rd4_ok", bus.ok_flag_to_lsu, k == 6);
      chk1("rd4_wr", bus.mem_wr, 1'b0);
      if (k <= 4) chk("rd4_a", bus.mem_a, 32'h100 + 32'(k) - 32'd1);
      if (k == 6) chk("rd4_data", bus.data_to_lsu, 32'h4433_2211);
    end

    // LSU write, 2 bytes at 0x200
    lsu_pulse(32'h200, 32'hDEAD_BEEF, 1'b1, 3'd2);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      chk1("wr2_ok", bus.ok_flag_to_lsu, k == 3);
      chk1("wr2_wr", bus.mem_wr, k <= 2);
      if (k == 1) begin chk("wr2_a0", bus.mem_a, 32'h200); chk("wr2_d0", {24'd0, bus.mem_dout}, 32'hEF); end
      if (k == 2) begin chk("wr2_a1", bus.mem_a, 32'h201); chk("wr2_d1", {24'd0, bus.mem_dout}, 32'hBE); end
    end

    // Fetch and LSU read in the same cycle: LSU first
    bus.en_signal_from_if = 1'b1;
    bus.addr_from_if = 32'h0;
    lsu_pulse(32'h300, 32'd0, 1'b0, 3'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      chk1("arb_ok_lsu", bus.ok_flag_to_lsu, k == 3);
      chk1("arb_ok_if", bus.ok_flag_to_if, k == 10);
      if (k == 1) chk("arb_lsu_a", bus.mem_a, 32'h300);
      if (k == 3) chk("arb_lsu_data", bus.data_to_lsu, 32'h0000_005A);
      if (k >= 5 && k <= 8) chk("arb_if_a", bus.mem_a, 32'(k) - 32'd5);
      if (k == 10) begin
        chk("arb_inst", bus.inst_to_if, 32'hDF9B_5713);
        bus.en_signal_from_if = 1'b0;
      end
    end

    // Rollback at cnt=2 of a fetch
    bus.en_signal_from_if = 1'b1;
    bus.addr_from_if = 32'h40;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      chk1("rb_if_ok", bus.ok_flag_to_if, 1'b0);
      if (k == 3) chk("rb_if_a2", bus.mem_a, 32'h42);
      if (k >= 4) chk("rb_if_idle_a", bus.mem_a, 32'd0);
      if (k == 3) begin rollback_flag_from_rob = 1'b1; bus.en_signal_from_if = 1'b0; end
      if (k == 4) rollback_flag_from_rob = 1'b0;
    end
    chk("rb_if_inst_hold", bus.inst_to_if, 32'hDF9B_5713);

    // Rollback during a 4-byte store: store completes
    wv = 32'h0102_0304;
    lsu_pulse(32'h210, wv, 1'b1, 3'd4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      chk1("rb_st_ok", bus.ok_flag_to_lsu, k == 5);
      chk1("rb_st_wr", bus.mem_wr, k <= 4);
      if (k <= 4) begin
        chk("rb_st_a", bus.mem_a, 32'h210 + 32'(k) - 32'd1);
        chk("rb_st_d", {24'd0, bus.mem_dout}, {24'd0, wv[8*(k-1) +: 8]});
      end
      if (k == 2) rollback_flag_from_rob = 1'b1;
      if (k == 3) rollback_flag_from_rob = 1'b0;
    end

    // Read wrapping past 0xFFFFFFFF
    lsu_pulse(32'hFFFF_FFFF, 32'd0, 1'b0, 3'd2);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      chk1("wrap_ok", bus.ok_flag_to_lsu, k == 4);
      if (k == 1) chk("wrap_a0", bus.mem_a, 32'hFFFF_FFFF);
      if (k == 2) chk("wrap_a1", bus.mem_a, 32'h0);
      if (k == 4) chk("wrap_data", bus.data_to_lsu, 32'h0000_133C);
    end

    // Rollback in the DONE cycle of a read suppresses ok
    lsu_pulse(32'h300, 32'd0, 1'b0, 3'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      if (k == 3) begin
        chk1("rb_done_pre", bus.ok_flag_to_lsu, 1'b1);
        rollback_flag_from_rob = 1'b1;
        #1;
        chk1("rb_done_ok", bus.ok_flag_to_lsu, 1'b0);
      end else begin
        chk1("rb_done_other", bus.ok_flag_to_lsu, 1'b0);
      end
      if (k == 4) rollback_flag_from_rob = 1'b0;
    end

    // rdy_in low freezes a 1-byte store
    lsu_pulse(32'h220, 32'h77, 1'b1, 3'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      chk1("rdy_ok", bus.ok_flag_to_lsu, k == 4);
      if (k == 1) begin
        chk1("rdy_wr1", bus.mem_wr, 1'b1);
        chk("rdy_d", {24'd0, bus.mem_dout}, 32'h77);
        rdy_in = 1'b0;
      end
      if (k == 2 || k == 3) begin
        chk1("rdy_wr_frozen", bus.mem_wr, 1'b0);
        chk("rdy_a_frozen", bus.mem_a, 32'h220);
      end
      if (k == 3) begin
        rdy_in = 1'b1;
        #1;
        chk1("rdy_wr_resume", bus.mem_wr, 1'b1);
      end
    end

    // Reset in the middle of a store
    lsu_pulse(32'h230, 32'hCAFE_F00D, 1'b1, 3'd4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      if (k <= 2) chk1("rst_mid_wr", bus.mem_wr, 1'b1);
      else begin
        chk1("rst_after_wr", bus.mem_wr, 1'b0);
        chk1("rst_after_ok", bus.ok_flag_to_lsu, 1'b0);
      end
      if (k == 2) begin
        rst_in = 1'b0;
        #1;
        chk1("rst_async_wr", bus.mem_wr, 1'b0);
        chk("rst_async_a", bus.mem_a, 32'd0);
        chk("rst_async_data", bus.data_to_lsu, 32'd0);
      end
      if (k == 3) rst_in = 1'b1;
    end

    // LSU pulse during a fetch is latched and served afterwards
    bus.en_signal_from_if = 1'b1;
    bus.addr_from_if = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      chk1("pend_ok_if", bus.ok_flag_to_if, k == 6);
      chk1("pend_ok_lsu", bus.ok_flag_to_lsu, k == 11);
      if (k == 8) chk("pend_a0", bus.mem_a, 32'h100);
      if (k == 9) chk("pend_a1", bus.mem_a, 32'h101);
      if (k == 11) chk("pend_data", bus.data_to_lsu, 32'h0000_2211);
      if (k == 2) lsu_pulse(32'h100, 32'd0, 1'b0, 3'd2);
      if (k == 3) bus.en_signal_from_lsu = 1'b0;
      if (k == 6) begin
        chk("pend_inst", bus.inst_to_if, 32'hDF9B_5713);
        bus.en_signal_from_if = 1'b0;
      end
    end

    // Store byte to an IO address with io_buffer_full high for 3 cycles
    io_buffer_full = 1'b1;
    lsu_pulse(32'h0003_0000, 32'h99, 1'b1, 3'd1);
`ifdef MEM_CTRL_IO_STALL_EN
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      chk1("io_ok", bus.ok_flag_to_lsu, k == 4);
      if (k <= 3) begin
        chk1("io_stall_wr", bus.mem_wr, 1'b0);
        chk("io_stall_a", bus.mem_a, 32'h0003_0000);
      end
      if (k == 3) begin
        io_buffer_full = 1'b0;
        #1;
        chk1("io_resume_wr", bus.mem_wr, 1'b1);
        chk("io_resume_d", {24'd0, bus.mem_dout}, 32'h99);
      end
    end
`else
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.en_signal_from_lsu = 1'b0;
      chk1("io_ok", bus.ok_flag_to_lsu, k == 2);
      chk1("io_wr", bus.mem_wr, k == 1);
      if (k == 1) chk("io_d", {24'd0, bus.mem_dout}, 32'h99);
      if (k == 2) io_buffer_full = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller directly downstream of the load/store execution unit. It also serves the instruction-fetch side.
- Accepts one-cycle load/store request pulses and level-held fetch requests, and arbitrates between them with the load/store side first.
- Serialises each access into 1/2/4 byte transfers on the 8-bit RAM/IO bus.
- Returns an ok pulse plus assembled little-endian data.

Parameters:
- IO_BASE_HI, 2'b11, value of addr[17:16] that marks an IO address.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state
- io_buffer_full  input  1  UART buffer full
- rollback_flag_from_rob  input  1  flush
- en_signal_from_lsu  input  1  one-cycle request pulse
- addr_from_lsu  input  32  byte address
- data_from_lsu  input  32  store data, low bytes used
- rw_flag_from_lsu  input  1  0 = read, 1 = write
- size_from_lsu  input  3  1, 2 or 4 bytes
- ok_flag_to_lsu  output  1  one-cycle done pulse (loads and stores)
- data_to_lsu  output  32  load data, zero-filled above size
- en_signal_from_if  input  1  fetch request, held until ok
- addr_from_if  input  32  fetch address
- ok_flag_to_if  output  1  one-cycle done pulse
- inst_to_if  output  32  fetched word
- mem_din  input  8  RAM/IO read byte
- mem_dout  output  8  write byte
- mem_a  output  32  bus address
- mem_wr  output  1  1 = write

Behaviour:
- Reset (rst_in=0, async):
  - All outputs 0.
  - State IDLE; pending latch cleared; byte counter 0.
- rdy_in=0:
  - No state change.
  - mem_wr is forced to 0 combinationally.
  - Registered outputs hold.
- Pending latch:
  - A load/store pulse arriving while not IDLE is latched (addr, data, rw, size).
  - The next pulse is guaranteed not to arrive before that ok.
  - rollback clears a latched read; it never clears a latched write.
- States: IDLE, LS_READ, LS_WRITE, IF_READ, DONE.
- IDLE:
  - Priority: live LSU pulse, then latched LSU request, then en_signal_from_if.
  - Enters the matching state with counter cnt=0.
  - mem_a and mem_wr are 0.
- Read states (n = size, or 4 for IF):
  - Each cycle cnt=0..n.
  - If cnt<n: mem_a=addr+cnt, mem_wr=0.
  - If cnt>=1: mem_din is byte cnt-1 and is stored at bits [8(cnt-1)+7 : 8(cnt-1)].
  - RAM read latency is one cycle from mem_a to mem_din.
  - At cnt=n, go to DONE.
- LS_WRITE:
  - For cnt=0..n-1: mem_a=addr+cnt, mem_wr=1, mem_dout=data[8cnt+7:8cnt].
  - After the last byte, go to DONE.
  - A write is never aborted by rollback.
- DONE:
  - Pulse the matching ok for exactly one cycle.
  - data_to_lsu or inst_to_if is valid in that same cycle and holds until the next ok.
  - Return to IDLE.
- Rollback in LS_READ or IF_READ:
  - Aborts to IDLE in the next cycle.
  - No ok pulse; mem_wr stays 0.
  - A rollback in DONE for a read suppresses that ok.
- Fetch held across an LSU request: serviced after the LSU access completes.
- Latency:
  - n-byte read ok is seen n+2 cycles after the request cycle.
  - n-byte write ok is seen n+1 cycles after the request cycle.
- Address increment is 32-bit modulo, with wrap at 0xFFFFFFFF.

Optional Feature:
- Macro MEM_CTRL_IO_STALL_EN.
- When defined, in LS_WRITE with addr[17:16]==IO_BASE_HI and io_buffer_full=1:
  - mem_wr=0 and cnt holds.
  - Resumes the cycle io_buffer_full drops.
- When undefined, io_buffer_full is ignored.

Test Plan:
- Reset mid-LS_WRITE (rst_in low 1 cycle) -> mem_wr=0 immediately, no ok, state IDLE.
- LSU read size=4, addr 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103, ok_flag_to_lsu at request+6, data_to_lsu=0x44332211.
- LSU write size=2, addr 0x200, data 0xDEADBEEF -> mem_a 0x200/0x201 with mem_dout EF/BE and mem_wr=1, ok at request+3.
- IF request at 0x0 with an LSU size=1 read pulse in the same cycle -> LSU served first with ok_flag_to_lsu, then fetch 0x0..0x3 with ok_flag_to_if.
- Rollback at cnt=2 of an IF read -> no ok_flag_to_if, IDLE next cycle. Rollback during a store -> store completes and ok pulses.
- MEM_CTRL_IO_STALL_EN: SB to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr low for 3 cycles, then one write, then ok.
